// File: rtl/sprite_mover.sv
// Sprite engine: scans a DxD box one pixel per tick, plotting a filled circle or
// square, then erases and redraws it at a clamped new position on each move request.
module sprite_mover #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int RADIUS      = 8,
  parameter int COLOUR_BITS = 3,
  parameter int DIV         = 500,
  parameter int X_INIT      = 50,
  parameter int Y_INIT      = 50,
  parameter int BG_COLOUR   = 0
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        up,
  input  logic                        down,
  input  logic                        left,
  input  logic                        right,
  input  logic [2:0]                  step,
  input  logic                        mode,
  input  logic [COLOUR_BITS-1:0]      fg_colour,
  output logic [$clog2(SCREEN_W)-1:0] x,
  output logic [$clog2(SCREEN_H)-1:0] y,
  output logic [COLOUR_BITS-1:0]      colour,
  output logic                        plot,
  output logic                        busy,
  output logic                        done
);

  localparam int D     = 2 * RADIUS + 1;
  localparam int XW    = $clog2(SCREEN_W);
  localparam int YW    = $clog2(SCREEN_H);
  localparam int CW    = $clog2(D + 1);
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW    = $clog2(2 * RADIUS * RADIUS + 2) + 2;
  localparam int X_MAX = SCREEN_W - D;
  localparam int Y_MAX = SCREEN_H - D;

  localparam logic [DW-1:0]        DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(D - 1);
  localparam logic signed [SW-1:0] R_SQ     = SW'(RADIUS * RADIUS);

  typedef enum logic [1:0] {
    S_DRAW  = 2'd0,
    S_IDLE  = 2'd1,
    S_ERASE = 2'd2,
    S_MOVE  = 2'd3
  } state_t;

  state_t                   state_r, next_state_s;
  logic [XW-1:0]            left_r, tgt_left_r, tgt_left_s;
  logic [YW-1:0]            top_r, tgt_top_r, tgt_top_s;
  logic [CW-1:0]            cx_r, cy_r;
  logic [DW-1:0]            div_r;
  logic                     last_r;
  logic [COLOUR_BITS-1:0]   fg_r;
  logic                     mode_r;
  logic [2:0]               step_s;
  logic                     scan_s, tick_s, accept_s, inside_s, busy_s, done_s;
  logic signed [SW-1:0]     dx_s, dy_s, dist_s;

  // last_r marks that the final tick of the pass has been emitted, blocking further ticks
  assign scan_s = (state_r == S_DRAW) || (state_r == S_ERASE);
  assign tick_s = scan_s && !last_r && (div_r == DIV_LAST);

  // Circle membership relative to the box centre, in signed arithmetic
  always_comb begin
    dx_s     = SW'(cx_r) - SW'(RADIUS);
    dy_s     = SW'(cy_r) - SW'(RADIUS);
    dist_s   = dx_s * dx_s + dy_s * dy_s;
    inside_s = mode_r ? 1'b1 : (dist_s <= R_SQ);
  end

  // Clamped move target with up > down > left > right priority
  always_comb begin
    step_s     = (step == 3'd0) ? 3'd1 : step;
    tgt_left_s = left_r;
    tgt_top_s  = top_r;
    if (up) begin
      if (top_r < YW'(step_s)) tgt_top_s = {YW{1'b0}};
      else                     tgt_top_s = top_r - YW'(step_s);
    end else if (down) begin
      if (({1'b0, top_r} + (YW+1)'(step_s)) > (YW+1)'(Y_MAX)) tgt_top_s = YW'(Y_MAX);
      else                                                     tgt_top_s = top_r + YW'(step_s);
    end else if (left) begin
      if (left_r < XW'(step_s)) tgt_left_s = {XW{1'b0}};
      else                      tgt_left_s = left_r - XW'(step_s);
    end else if (right) begin
      if (({1'b0, left_r} + (XW+1)'(step_s)) > (XW+1)'(X_MAX)) tgt_left_s = XW'(X_MAX);
      else                                                      tgt_left_s = left_r + XW'(step_s);
    end else begin
      tgt_left_s = left_r;
      tgt_top_s  = top_r;
    end
    accept_s = (up || down || left || right) &&
               ((tgt_left_s != left_r) || (tgt_top_s != top_r));
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_r <= S_DRAW;
    else       state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_DRAW:  next_state_s = last_r ? S_IDLE : S_DRAW;
      S_IDLE:  next_state_s = accept_s ? S_ERASE : S_IDLE;
      S_ERASE: next_state_s = last_r ? S_MOVE : S_ERASE;
      S_MOVE:  next_state_s = S_DRAW;
      default: next_state_s = S_DRAW;
    endcase
  end

  // FSM status decode, registered in the datapath below
  always_comb begin
    busy_s = (next_state_s != S_IDLE);
    done_s = (state_r == S_DRAW) && last_r;
  end

  // Scan counters, divider, position, latches and registered pixel outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      left_r     <= XW'(X_INIT);
      top_r      <= YW'(Y_INIT);
      tgt_left_r <= XW'(X_INIT);
      tgt_top_r  <= YW'(Y_INIT);
      cx_r       <= {CW{1'b0}};
      cy_r       <= {CW{1'b0}};
      div_r      <= {DW{1'b0}};
      last_r     <= 1'b0;
      fg_r       <= fg_colour;
      mode_r     <= mode;
      x          <= XW'(X_INIT);
      y          <= YW'(Y_INIT);
      colour     <= {COLOUR_BITS{1'b0}};
      plot       <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      busy <= busy_s;
      done <= done_s;
      if (scan_s) div_r <= (div_r == DIV_LAST) ? {DW{1'b0}} : div_r + DW'(1);
      else        div_r <= {DW{1'b0}};
      if (tick_s) begin
        x      <= left_r + XW'(cx_r);
        y      <= top_r + YW'(cy_r);
        colour <= (state_r == S_DRAW) ? fg_r : COLOUR_BITS'(BG_COLOUR);
        plot   <= inside_s;
        if (cx_r == CNT_LAST) begin
          cx_r <= {CW{1'b0}};
          if (cy_r == CNT_LAST) begin
            cy_r   <= {CW{1'b0}};
            last_r <= 1'b1;
          end else begin
            cy_r <= cy_r + CW'(1);
          end
        end else begin
          cx_r <= cx_r + CW'(1);
        end
      end
      case (state_r)
        S_IDLE: begin
          last_r <= 1'b0;
          if (accept_s) begin
            tgt_left_r <= tgt_left_s;
            tgt_top_r  <= tgt_top_s;
          end
        end
        S_MOVE: begin
          left_r <= tgt_left_r;
          top_r  <= tgt_top_r;
          cx_r   <= {CW{1'b0}};
          cy_r   <= {CW{1'b0}};
          last_r <= 1'b0;
          fg_r   <= fg_colour;
          mode_r <= mode;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: pixel scoreboard per instance, table of move vectors,
// plus hand sequences for clamping, reset mid-erase and a slow-divider square.
module tb_sprite_mover;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  typedef struct {
    bit         u;
    bit         d;
    bit         l;
    bit         r;
    logic [2:0] st;
    bit         md;
    logic [2:0] fg;
    int         el;
    int         et;
    bit         mv;
  } vec_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset_a, reset_b;
  logic       up, down, left, right, mode;
  logic [2:0] step, fg_colour;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] colour_a, colour_b;
  logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   plots_a = 0;
  int   plots_b = 0;
  pix_t qa[$];
  pix_t qb[$];
  pix_t pa, pb;
  bit   space_chk_b = 1'b0;
  bit   have_prev_b = 1'b0;
  int   prev_cyc_b = 0;
  int   ml, mt;
  bit   mm;
  vec_t vt[6];

  always #5 CLOCK_50 = ~CLOCK_50;

  sprite_mover #(.SCREEN_W(160), .SCREEN_H(120), .RADIUS(2), .COLOUR_BITS(3), .DIV(1),
                 .X_INIT(50), .Y_INIT(50), .BG_COLOUR(0)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset_a), .up(up), .down(down), .left(left), .right(right),
    .step(step), .mode(mode), .fg_colour(fg_colour), .x(x_a), .y(y_a), .colour(colour_a),
    .plot(plot_a), .busy(busy_a), .done(done_a));

  sprite_mover #(.SCREEN_W(160), .SCREEN_H(120), .RADIUS(2), .COLOUR_BITS(3), .DIV(4),
                 .X_INIT(50), .Y_INIT(50), .BG_COLOUR(0)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset_b), .up(up), .down(down), .left(left), .right(right),
    .step(step), .mode(mode), .fg_colour(fg_colour), .x(x_b), .y(y_b), .colour(colour_b),
    .plot(plot_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixels of one pass, in raster order, onto the selected scoreboard
  task automatic push_pass(input bit sel, input int l, input int t, input bit sq, input int col);
    pix_t p;
    for (int cy = 0; cy < 5; cy++)
      for (int cx = 0; cx < 5; cx++)
        if (sq || ((cx - 2) * (cx - 2) + (cy - 2) * (cy - 2) <= 4)) begin
          p.x = l + cx; p.y = t + cy; p.c = col;
          if (sel) qb.push_back(p); else qa.push_back(p);
        end
  endtask

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (plot_a) begin
      plots_a++;
      if (qa.size() == 0) chk("plot_unexpected_a", 1, 0);
      else begin
        pa = qa.pop_front();
        chk("pix_x_a", int'(x_a), pa.x);
        chk("pix_y_a", int'(y_a), pa.y);
        chk("pix_colour_a", int'(colour_a), pa.c);
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (!space_chk_b) have_prev_b = 1'b0;
    if (plot_b) begin
      plots_b++;
      if (space_chk_b && have_prev_b) chk("plot_spacing_b", cyc - prev_cyc_b, 4);
      prev_cyc_b  = cyc;
      have_prev_b = 1'b1;
      if (qb.size() == 0) chk("plot_unexpected_b", 1, 0);
      else begin
        pb = qb.pop_front();
        chk("pix_x_b", int'(x_b), pb.x);
        chk("pix_y_b", int'(y_b), pb.y);
        chk("pix_colour_b", int'(colour_b), pb.c);
      end
    end
  end

  // Counts negedges until done; n=1 is the clock that sampled the request/release
  task automatic wait_done(input bit sel, input int exp_n, input bit noise, input string name);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < exp_n + 50) begin
      @(negedge CLOCK_50); #1;
      n++;
      up = 1'b0; left = 1'b0; right = 1'b0;
      down = noise && (n < 20);
      got = sel ? done_b : done_a;
    end
    down = 1'b0;
    if (!got) chk({name, "_timeout"}, 0, 1);
    else begin
      chk(name, n, exp_n);
      chk({name, "_busy_low"}, int'(sel ? busy_b : busy_a), 0);
      chk({name, "_queue_empty"}, sel ? qb.size() : qa.size(), 0);
      @(negedge CLOCK_50); #1;
      chk({name, "_done_pulse"}, int'(sel ? done_b : done_a), 0);
    end
  endtask

  task automatic do_move(input bit u, input bit d, input bit l, input bit r, input logic [2:0] st,
                         input bit md, input logic [2:0] fg, input int el, input int et,
                         input bit mv, input bit noise);
    up = u; down = d; left = l; right = r; step = st; mode = md; fg_colour = fg;
    if (mv) begin
      push_pass(1'b0, ml, mt, mm, 0);
      push_pass(1'b0, el, et, md, int'(fg));
      ml = el; mt = et; mm = md;
      wait_done(1'b0, 2 * 25 + 4, noise, "move_latency");
    end else begin
      for (int i = 0; i < 6; i++) begin
        @(negedge CLOCK_50); #1;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        chk("ignored_busy", int'(busy_a), 0);
      end
      chk("ignored_queue", qa.size(), 0);
    end
  endtask

  initial begin
    int base;
    bit hit;
    // u d l r step mode fg -> expected left, top, moved
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 53, 50, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 53, 49, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 3'd6, 53, 42, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd1, 48, 42, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd2, 48, 44, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 3'd7, 41, 44, 1'b1};

    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    step = 3'd1; mode = 1'b0; fg_colour = 3'd5;
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("rst_plot", int'(plot_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_busy", int'(busy_a), 1);
    chk("rst_x", int'(x_a), 50);
    chk("rst_y", int'(y_a), 50);
    chk("rst_colour", int'(colour_a), 0);
    chk("rst_busy_b", int'(busy_b), 1);

    // Reset draw: circle at (50,50), one tick per clock
    push_pass(1'b0, 50, 50, 1'b0, 5);
    ml = 50; mt = 50; mm = 1'b0;
    base = plots_a;
    reset_a = 1'b0;
    wait_done(1'b0, 26, 1'b0, "reset_latency");
    chk("reset_draw_plots", plots_a - base, 13);

    for (int i = 0; i < 6; i++)
      do_move(vt[i].u, vt[i].d, vt[i].l, vt[i].r, vt[i].st, vt[i].md, vt[i].fg,
              vt[i].el, vt[i].et, vt[i].mv, i == 1);

    // Walk to the top edge; the last step of 5 from top=4 clamps to 0
    for (int k = 1; k <= 8; k++)
      do_move(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 3'(k), 41, 44 - 5 * k, 1'b1, 1'b0);
    do_move(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 3'd6, 41, 0, 1'b1, 1'b0);
    do_move(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd6, 41, 0, 1'b0, 1'b0);

    // Walk to the right edge, then clamp 154+3 to 155 and ignore a further push
    for (int k = 1; k <= 16; k++)
      do_move(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 3'd2, 41 + 7 * k, 0, 1'b1, 1'b0);
    do_move(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd3, 154, 0, 1'b1, 1'b0);
    do_move(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd4, 155, 0, 1'b1, 1'b0);
    do_move(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd4, 155, 0, 1'b0, 1'b0);

    // Reset after the seventh erase pixel
    left = 1'b1; step = 3'd3;
    push_pass(1'b0, ml, mt, mm, 0);
    base = plots_a;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge CLOCK_50); #1;
      left = 1'b0;
      hit = (plots_a - base) >= 7;
    end
    chk("erase_seven_reached", int'(hit), 1);
    reset_a = 1'b1;
    @(negedge CLOCK_50); #1;
    chk("plot_after_reset", int'(plot_a), 0);
    qa.delete();
    mode = 1'b0; fg_colour = 3'd4;
    @(negedge CLOCK_50); #1;
    chk("midreset_busy", int'(busy_a), 1);
    push_pass(1'b0, 50, 50, 1'b0, 4);
    ml = 50; mt = 50; mm = 1'b0;
    base = plots_a;
    reset_a = 1'b0;
    wait_done(1'b0, 26, 1'b0, "redraw_latency");
    chk("redraw_plots", plots_a - base, 13);

    // Square with DIV=4 on the second instance, then erase after mode switches to circle
    reset_a = 1'b1;
    mode = 1'b1; fg_colour = 3'd2;
    @(negedge CLOCK_50); #1;
    push_pass(1'b1, 50, 50, 1'b1, 2);
    space_chk_b = 1'b1;
    reset_b = 1'b0;
    wait_done(1'b1, 101, 1'b0, "b_reset_latency");
    space_chk_b = 1'b0;
    chk("b_square_plots", plots_b, 25);
    right = 1'b1; step = 3'd3; mode = 1'b0; fg_colour = 3'd7;
    push_pass(1'b1, 50, 50, 1'b1, 0);
    push_pass(1'b1, 53, 50, 1'b0, 7);
    wait_done(1'b1, 2 * 100 + 4, 1'b0, "b_move_latency");
    chk("b_total_plots", plots_b, 25 + 25 + 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
